// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel prescaler, x/y counters, registered sync/active, frame pulse.
// Optional sticky frame flag with frame_ack clear is compiled in by defining VGA_FRAME_FLAG_EN.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pix_tick,
    output logic       hsync,
    output logic       vsync,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic       frame_start,
    input  logic       frame_ack,
    output logic       frame_flag
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);

    localparam logic [9:0] H_MAX    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_MAX    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HA       = 10'(H_ACTIVE);
    localparam logic [9:0] VA       = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [PW-1:0] prescale_q;
    logic [9:0]    x_q, x_d, y_q, y_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d, active_q, active_d;
    logic          frame_start_q, frame_wrap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescale_q <= '0;
        end else if (prescale_q >= PRE_MAX) begin
            prescale_q <= '0;
        end else begin
            prescale_q <= prescale_q + 1'b1;
        end
    end

    assign pix_tick = (prescale_q == PRE_MAX);

    // Sync and active are decoded from the next count so they land on the same edge as x/y.
    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        frame_wrap = 1'b0;
        if (x_q >= H_MAX) begin
            x_d = '0;
            if (y_q >= V_MAX) begin
                y_d        = '0;
                frame_wrap = 1'b1;
            end else begin
                y_d = y_q + 10'd1;
            end
        end else begin
            x_d = x_q + 10'd1;
        end
        hsync_d  = !((x_d >= HS_START) && (x_d < HS_END));
        vsync_d  = !((y_d >= VS_START) && (y_d < VS_END));
        active_d = (x_d < HA) && (y_d < VA);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q           <= '0;
            y_q           <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            active_q      <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= pix_tick && frame_wrap;
            if (pix_tick) begin
                x_q      <= x_d;
                y_q      <= y_d;
                hsync_q  <= hsync_d;
                vsync_q  <= vsync_d;
                active_q <= active_d;
            end
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign active      = active_q;
    assign frame_start = frame_start_q;

`ifdef VGA_FRAME_FLAG_EN
    logic frame_flag_q;

    // Set wins over a coincident ack so a new frame is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_flag_q <= 1'b0;
        end else if (frame_start_q) begin
            frame_flag_q <= 1'b1;
        end else if (frame_ack) begin
            frame_flag_q <= 1'b0;
        end
    end

    assign frame_flag = frame_flag_q;
`else
    logic unused_frame_ack;
    assign unused_frame_ack = frame_ack;
    assign frame_flag       = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: closed-form raster model per clk plus hand-computed checkpoints.
// A shortened vertical timing keeps a whole frame inside the simulation budget.
module tb_vga_timing_gen;

    localparam int unsigned CLK_DIV = 2;
    localparam int unsigned HA = 640, HF = 16, HS = 96, HB = 48;
    localparam int unsigned VA = 20, VF = 2, VS = 2, VB = 3;
    localparam int unsigned HT = HA + HF + HS + HB;
    localparam int unsigned VT = VA + VF + VS + VB;
    localparam int unsigned FRAME = CLK_DIV * HT * VT;
`ifdef VGA_FRAME_FLAG_EN
    localparam bit FLAG_ON = 1'b1;
`else
    localparam bit FLAG_ON = 1'b0;
`endif

    logic       clk, reset, pix_tick, hsync, vsync, active, frame_start, frame_ack, frame_flag;
    logic [9:0] x, y;

    vga_timing_gen #(
        .CLK_DIV (CLK_DIV),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_tick   (pix_tick),
        .hsync      (hsync),
        .vsync      (vsync),
        .x          (x),
        .y          (y),
        .active     (active),
        .frame_start(frame_start),
        .frame_ack  (frame_ack),
        .frame_flag (frame_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int unsigned n;
        logic [9:0]  x, y;
        logic        hs, vs, act, pt, fs, ff;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        tbl[$];
    int          idx;
    int unsigned cnt;
    int          checks, errors;
    logic        flag_m;
    bit          phase2;

    function automatic exp_t mk(string name, int unsigned n, int unsigned xv, int unsigned yv,
                                bit hs, bit vs, bit act, bit pt, bit fs, bit ff);
        exp_t e;
        e.name = name; e.n = n; e.x = 10'(xv); e.y = 10'(yv);
        e.hs = hs; e.vs = vs; e.act = act; e.pt = pt; e.fs = fs; e.ff = ff;
        return e;
    endfunction

    // Expected outputs n clks after reset release, computed from elapsed time alone.
    function automatic exp_t model(int unsigned n);
        int unsigned t, xv, yv;
        t  = n / CLK_DIV;
        xv = t % HT;
        yv = (t / HT) % VT;
        return mk("model", n, xv, yv,
                  !(xv >= HA + HF && xv < HA + HF + HS),
                  !(yv >= VA + VF && yv < VA + VF + VS),
                  (xv < HA) && (yv < VA),
                  (n % CLK_DIV) == CLK_DIV - 1,
                  (n != 0) && (n % FRAME == 0),
                  flag_m);
    endfunction

    task automatic check(exp_t e);
        logic [25:0] got, want;
        got  = {x, y, hsync, vsync, active, pix_tick, frame_start, frame_flag};
        want = {e.x, e.y, e.hs, e.vs, e.act, e.pt, e.fs, e.ff};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s n=%0d got x=%0d y=%0d hs/vs/act/pt/fs/ff=%b required x=%0d y=%0d hs/vs/act/pt/fs/ff=%b",
                     e.name, e.n, x, y, got[5:0], e.x, e.y, want[5:0]);
        end
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0) check(sb_q.pop_front());
    end

    task automatic push_now();
        sb_q.push_back(model(cnt));
        while (phase2 && idx < tbl.size() && tbl[idx].n == cnt) begin
            sb_q.push_back(tbl[idx]);
            idx++;
        end
    endtask

    task automatic step();
        bit fs_prev;
        #1;
        frame_ack = phase2 && cnt >= 43195 && cnt <= 43205;
        fs_prev   = (cnt != 0) && (cnt % FRAME == 0);
        @(posedge clk);
`ifdef VGA_FRAME_FLAG_EN
        if (fs_prev) flag_m = 1'b1;
        else if (frame_ack) flag_m = 1'b0;
`else
        fs_prev = fs_prev;
`endif
        cnt++;
        push_now();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        frame_ack = 1'b0;
        flag_m    = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        cnt   = 0;
        push_now();
    endtask

    initial begin
        checks = 0; errors = 0; idx = 0; cnt = 0; phase2 = 1'b0; flag_m = 1'b0;
        reset = 1'b1; frame_ack = 1'b0;

        //             name        n      x    y   hs vs act pt fs ff
        tbl.push_back(mk("reset",   0,     0,   0,  1, 1, 1, 0, 0, 0));
        tbl.push_back(mk("tick1",   1,     0,   0,  1, 1, 1, 1, 0, 0));
        tbl.push_back(mk("x8",      16,    8,   0,  1, 1, 1, 0, 0, 0));
        tbl.push_back(mk("x639",    1278,  639, 0,  1, 1, 1, 0, 0, 0));
        tbl.push_back(mk("x640",    1280,  640, 0,  1, 1, 0, 0, 0, 0));
        tbl.push_back(mk("x655",    1310,  655, 0,  1, 1, 0, 0, 0, 0));
        tbl.push_back(mk("x656",    1312,  656, 0,  0, 1, 0, 0, 0, 0));
        tbl.push_back(mk("x751",    1502,  751, 0,  0, 1, 0, 0, 0, 0));
        tbl.push_back(mk("x752",    1504,  752, 0,  1, 1, 0, 0, 0, 0));
        tbl.push_back(mk("x799",    1598,  799, 0,  1, 1, 0, 0, 0, 0));
        tbl.push_back(mk("line",    1600,  0,   1,  1, 1, 1, 0, 0, 0));
        tbl.push_back(mk("y22",     35200, 0,   22, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("y23end",  38398, 799, 23, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("y24",     38400, 0,   24, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk("last",    43199, 799, 26, 1, 1, 0, 1, 0, 0));
        tbl.push_back(mk("wrap",    43200, 0,   0,  1, 1, 1, 0, 1, 0));
        tbl.push_back(mk("flagset", 43201, 0,   0,  1, 1, 1, 1, 0, FLAG_ON));
        tbl.push_back(mk("flagclr", 43202, 1,   0,  1, 1, 1, 0, 0, 0));

        do_reset();

        // Run into the frame, then hit reset between edges at (300, 10).
        repeat (16600) step();
        #7;
        reset = 1'b1;
        #1;
        check(mk("async_rst", 0, 0, 0, 1, 1, 1, 0, 0, 0));

        phase2 = 1'b1;
        do_reset();
        while (cnt < 43205) step();
        @(negedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
